// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state/select enums and default widths for the fetch unit
package fetch_pkg;

    localparam int FETCH_A     = 12;
    localparam int FETCH_W     = 10;
    localparam int FETCH_OFF_W = 6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_RUN    = 2'd2,
        S_HALTED = 2'd3
    } fetch_state_t;

    typedef enum logic [2:0] {
        NPC_HOLD = 3'd0,
        NPC_INC  = 3'd1,
        NPC_ABS  = 3'd2,
        NPC_REL  = 3'd3,
        NPC_ZERO = 3'd4
    } npc_sel_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - host/decode/ROM side signals of the fetch unit
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int A     = FETCH_A,
    parameter int W     = FETCH_W,
    parameter int OFF_W = FETCH_OFF_W
);
    logic             start;
    logic             halt;
    logic             stall;
    logic             branch_abs;
    logic             branch_rel;
    logic [A-1:0]     target;
    logic [OFF_W-1:0] offset;
    logic [W-1:0]     inst_in;
    logic [A-1:0]     inst_address;
    logic [W-1:0]     inst_out;
    logic [A-1:0]     inst_pc;
    logic             inst_valid;
    logic             ack;
    logic [31:0]      cycle_count;

    modport master (
        output start, halt, stall, branch_abs, branch_rel, target, offset, inst_in,
        input  inst_address, inst_out, inst_pc, inst_valid, ack, cycle_count
    );

    modport slave (
        input  start, halt, stall, branch_abs, branch_rel, target, offset, inst_in,
        output inst_address, inst_out, inst_pc, inst_valid, ack, cycle_count
    );
endinterface

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - combinational next-PC mux (hold/increment/absolute/relative/zero)
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int A     = FETCH_A,
    parameter int OFF_W = FETCH_OFF_W
) (
    input  npc_sel_t         sel,
    input  logic [A-1:0]     pc,
    input  logic [A-1:0]     inst_pc,
    input  logic [A-1:0]     target,
    input  logic [OFF_W-1:0] offset,
    output logic [A-1:0]     next_pc
);
    logic [A-1:0] rel_off;

    // relative targets are taken from the address of the branch itself, not the PC
    assign rel_off = {{(A-OFF_W){offset[OFF_W-1]}}, offset};

    always_comb begin
        case (sel)
            NPC_INC:  next_pc = pc + A'(1);
            NPC_ABS:  next_pc = target;
            NPC_REL:  next_pc = inst_pc + rel_off;
            NPC_ZERO: next_pc = '0;
            default:  next_pc = pc;
        endcase
    end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM with branch/halt/stall; FETCH_CYCLE_COUNT_EN adds a RUN-cycle counter
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int A     = FETCH_A,
    parameter int W     = FETCH_W,
    parameter int OFF_W = FETCH_OFF_W
) (
    input  logic   clk,
    input  logic   rst,
    fetch_if.slave bus
);
    fetch_state_t state;
    npc_sel_t     sel;
    logic [A-1:0] pc;
    logic [A-1:0] next_pc;
    logic [W-1:0] inst_out;
    logic [A-1:0] inst_pc;
    logic         inst_valid;
    logic         take_halt;
    logic         take_branch;

    // decode feedback only means something while a live instruction sits in the fetch register
    assign take_halt   = inst_valid & bus.halt;
    assign take_branch = inst_valid & (bus.branch_abs | bus.branch_rel);

    always_comb begin
        sel = NPC_HOLD;
        case (state)
            S_IDLE:   if (bus.start) sel = NPC_ZERO;
            S_ARMED:  sel = NPC_ZERO;
            S_RUN: begin
                if (take_halt)           sel = NPC_HOLD;
                else if (take_branch)    sel = bus.branch_abs ? NPC_ABS : NPC_REL;
                else if (bus.stall)      sel = NPC_HOLD;
                else                     sel = NPC_INC;
            end
            S_HALTED: if (bus.start) sel = NPC_ZERO;
            default:  sel = NPC_HOLD;
        endcase
    end

    fetch_next_pc #(.A(A), .OFF_W(OFF_W)) u_next_pc (
        .sel     (sel),
        .pc      (pc),
        .inst_pc (inst_pc),
        .target  (bus.target),
        .offset  (bus.offset),
        .next_pc (next_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            inst_out   <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else begin
            pc <= next_pc;
            case (state)
                S_IDLE:   if (bus.start) state <= S_ARMED;
                S_ARMED:  if (!bus.start) state <= S_RUN;
                S_RUN: begin
                    if (take_halt) begin
                        state      <= S_HALTED;
                        inst_valid <= 1'b0;
                    end else if (take_branch) begin
                        inst_valid <= 1'b0;
                    end else if (!bus.stall) begin
                        inst_out   <= bus.inst_in;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                    end
                end
                S_HALTED: if (bus.start) state <= S_ARMED;
                default:  state <= S_IDLE;
            endcase
        end
    end

`ifdef FETCH_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
    logic        enter_armed;

    assign enter_armed = ((state == S_IDLE) || (state == S_HALTED)) && bus.start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 cycle_count <= '0;
        else if (state == S_RUN) cycle_count <= cycle_count + 32'd1;
        else if (enter_armed)    cycle_count <= '0;
    end

    assign bus.cycle_count = cycle_count;
`else
    assign bus.cycle_count = '0;
`endif

    assign bus.inst_address = pc;
    assign bus.inst_out     = inst_out;
    assign bus.inst_pc      = inst_pc;
    assign bus.inst_valid   = inst_valid;
    assign bus.ack          = (state == S_HALTED);
endmodule
